id_ex_reg: RTL and testbench
============================

# id_ex_reg

ID/EX pipeline register of the 5-stage pipelined CPU. Captures the decode-stage outputs (the 32-bit extended immediate from the immediate-extension unit, both register-file read values, register specifiers, shift amount, PC+4 and the decoded control bundle) and presents them to the execute stage one cycle later. It supports hold (downstream stall) and bubble insertion (flush) and keeps a saturating count of inserted bubbles. Under an optional macro, it also bypasses same-cycle writeback data into its captured register operands.

## Interface
- DATA_W, 32, datapath width (PC, immediate, operands)
- REG_AW, 5, register specifier width
- CNT_W, 16, bubble counter width
- clk  in  1  pipeline clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- Stall  in  1  hold all fields (EX stage not ready)
- Flush  in  1  load a bubble (hazard unit / branch taken)
- ID_PC4, ID_ImmExt, ID_RsData, ID_RtData  in  DATA_W each  decode-stage values
- ID_Rs, ID_Rt, ID_Rd  in  REG_AW each  register specifiers
- ID_Shamt  in  5  shift amount
- ID_Ctrl  in  16  control bundle: [0] RegWrite, [1] MemRead, [2] MemWrite, [4:3] MemtoReg, [6:5] RegDst, [7] ALUSrcA, [8] ALUSrcB, [12:9] ALUOp, [13] Branch, [15:14] reserved
- WB_RegWrite  in  1  writeback write enable (bypass use only)
- WB_WriteAddr  in  REG_AW  writeback destination
- WB_WriteData  in  DATA_W  writeback data
- EX_PC4, EX_ImmExt, EX_RsData, EX_RtData  out  DATA_W  registered copies
- EX_Rs, EX_Rt, EX_Rd  out  REG_AW  registered
- EX_Shamt  out  5  registered
- EX_Ctrl  out  16  registered control bundle
- EX_Valid  out  1  1 = real instruction, 0 = bubble
- BubbleCnt  out  CNT_W  number of flush-inserted bubbles, saturating

## Operation
- Per-edge priority: reset > Flush > Stall > load.
- reset: all outputs cleared to 0, including EX_Valid and BubbleCnt.
- Flush (regardless of Stall): every EX_* field is set to 0 and EX_Valid is set to 0. BubbleCnt increments by 1 and saturates at all-ones.
- Stall and not Flush: every field holds its value. With the macro enabled, held operands may still be updated by the bypass (see Configuration).
- Otherwise (load): every ID_* field is copied to its EX_* counterpart and EX_Valid is set to 1.
- Bubble encoding: EX_Ctrl = 0, so RegWrite, MemWrite, MemRead and Branch are all 0. A bubble therefore has no architectural side effects.
- Register $0 is never a bypass match. WB_WriteAddr = 0 never alters an operand.
- No combinational path from any input to any output.

## Timing
- Latency: exactly 1 cycle. ID_* values sampled at edge N appear on EX_* immediately after edge N.
- Stall held for k cycles: outputs are unchanged for k edges. The ID_* value present at the first non-stalled edge is then loaded.
- Flush and Stall asserted together: a bubble is loaded and the held instruction is discarded.
- reset asserted mid-stream: outputs are 0 after that edge and BubbleCnt is 0. The first load after reset deasserts gives EX_Valid = 1.
- BubbleCnt wrap-around: never wraps. At 2^CNT_W−1, further flushes leave it unchanged.

## Configuration
- ID_EX_WB_BYPASS_EN defined:
  - On a load edge, if WB_RegWrite = 1, WB_WriteAddr ≠ 0 and WB_WriteAddr = ID_Rs, then EX_RsData takes WB_WriteData instead of ID_RsData. The same rule applies to Rt / EX_RtData, independently.
  - On a stall edge, if WB_RegWrite = 1, WB_WriteAddr ≠ 0 and WB_WriteAddr = EX_Rs (or EX_Rt), the held EX_RsData (or EX_RtData) is replaced with WB_WriteData. This prevents stale operands after a long stall.
  - Flush and reset are unaffected.
- Not defined:
  - WB_* inputs are ignored.
  - Operands are loaded or held exactly as received.
  - This relies on the register file's write-first read behaviour.

## Test plan
- Reset then load: reset = 1 for 2 cycles, then ID_ImmExt = 0xFFFF8000, ID_Ctrl = 0x0001, no stall or flush → all outputs 0 during reset; one edge after reset deasserts, EX_ImmExt = 0xFFFF8000, EX_Ctrl = 0x0001, EX_Valid = 1.
- Stall hold: load ID_RsData = 0x12345678, then Stall = 1 for 3 cycles while ID_RsData = 0xDEADBEEF → EX_RsData stays 0x12345678 for 3 cycles and becomes 0xDEADBEEF one edge after Stall deasserts.
- Flush priority: Stall = 1 and Flush = 1 together with ID_Ctrl = 0x3FFF → EX_Ctrl = 0, EX_Valid = 0, BubbleCnt goes 0 → 1.
- Counter saturation: with CNT_W = 4, apply 20 consecutive flushes → BubbleCnt = 15 and stays 15.
- Bypass (macro on):
  - Load with ID_Rs = 5, ID_RsData = 0x1, WB_RegWrite = 1, WB_WriteAddr = 5, WB_WriteData = 0xAA → EX_RsData = 0xAA.
  - Same stimulus with WB_WriteAddr = 0 → EX_RsData = 0x1.
- Bypass during stall (macro on): hold with EX_Rt = 9, then WB writes reg 9 = 0x77 → EX_RtData = 0x77 while Stall stays asserted. With the macro off, EX_RtData is unchanged.

Source files
------------

// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline register bus: decode-side inputs, stall/flush controls,
// writeback bypass feed and the registered execute-side outputs.
interface id_ex_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  // Stall: EX not ready, hold every field. Flush: replace contents with a
  // bubble. Flush wins over Stall; both act on the rising clock edge only.
  logic              Stall;
  logic              Flush;
  logic [DATA_W-1:0] ID_PC4, ID_ImmExt, ID_RsData, ID_RtData;
  logic [REG_AW-1:0] ID_Rs, ID_Rt, ID_Rd;
  logic [4:0]        ID_Shamt;
  logic [15:0]       ID_Ctrl;
  logic              WB_RegWrite;
  logic [REG_AW-1:0] WB_WriteAddr;
  logic [DATA_W-1:0] WB_WriteData;
  logic [DATA_W-1:0] EX_PC4, EX_ImmExt, EX_RsData, EX_RtData;
  logic [REG_AW-1:0] EX_Rs, EX_Rt, EX_Rd;
  logic [4:0]        EX_Shamt;
  logic [15:0]       EX_Ctrl;
  logic              EX_Valid;
  logic [CNT_W-1:0]  BubbleCnt;

  modport master (
    output Stall, Flush, ID_PC4, ID_ImmExt, ID_RsData, ID_RtData,
           ID_Rs, ID_Rt, ID_Rd, ID_Shamt, ID_Ctrl,
           WB_RegWrite, WB_WriteAddr, WB_WriteData,
    input  EX_PC4, EX_ImmExt, EX_RsData, EX_RtData, EX_Rs, EX_Rt, EX_Rd,
           EX_Shamt, EX_Ctrl, EX_Valid, BubbleCnt
  );

  modport slave (
    input  Stall, Flush, ID_PC4, ID_ImmExt, ID_RsData, ID_RtData,
           ID_Rs, ID_Rt, ID_Rd, ID_Shamt, ID_Ctrl,
           WB_RegWrite, WB_WriteAddr, WB_WriteData,
    output EX_PC4, EX_ImmExt, EX_RsData, EX_RtData, EX_Rs, EX_Rt, EX_Rd,
           EX_Shamt, EX_Ctrl, EX_Valid, BubbleCnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall hold, flush bubbles and a saturating
// bubble counter. Define ID_EX_WB_BYPASS_EN to forward writeback data into operands.
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic        clk,
  input logic        reset,
  id_ex_reg_if.slave bus
);
  logic [DATA_W-1:0] pc4Q, immQ, rsDataQ, rtDataQ;
  logic [REG_AW-1:0] rsQ, rtQ, rdQ;
  logic [4:0]        shamtQ;
  logic [15:0]       ctrlQ;
  logic              validQ;
  logic [CNT_W-1:0]  cntQ;

  // Operand values chosen for a load edge and for a stall edge.
  logic [DATA_W-1:0] rsLoad, rtLoad, rsHold, rtHold;

`ifdef ID_EX_WB_BYPASS_EN
  logic wbLive;
  assign wbLive = bus.WB_RegWrite && (bus.WB_WriteAddr != '0);

  always_comb begin
    rsLoad = bus.ID_RsData;
    rtLoad = bus.ID_RtData;
    rsHold = rsDataQ;
    rtHold = rtDataQ;
    if (wbLive && (bus.WB_WriteAddr == bus.ID_Rs)) rsLoad = bus.WB_WriteData;
    if (wbLive && (bus.WB_WriteAddr == bus.ID_Rt)) rtLoad = bus.WB_WriteData;
    // Refresh held operands so a long stall never leaves stale values.
    if (wbLive && (bus.WB_WriteAddr == rsQ)) rsHold = bus.WB_WriteData;
    if (wbLive && (bus.WB_WriteAddr == rtQ)) rtHold = bus.WB_WriteData;
  end
`else
  // The register file reads write-first, so no forwarding is needed here.
  assign rsLoad = bus.ID_RsData;
  assign rtLoad = bus.ID_RtData;
  assign rsHold = rsDataQ;
  assign rtHold = rtDataQ;

  logic unusedWb;
  assign unusedWb = ^{bus.WB_RegWrite, bus.WB_WriteAddr, bus.WB_WriteData};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc4Q    <= '0;
      immQ    <= '0;
      rsDataQ <= '0;
      rtDataQ <= '0;
      rsQ     <= '0;
      rtQ     <= '0;
      rdQ     <= '0;
      shamtQ  <= '0;
      ctrlQ   <= '0;
      validQ  <= 1'b0;
      cntQ    <= '0;
    end else if (bus.Flush) begin
      // A bubble carries an all-zero control bundle: no side effects.
      pc4Q    <= '0;
      immQ    <= '0;
      rsDataQ <= '0;
      rtDataQ <= '0;
      rsQ     <= '0;
      rtQ     <= '0;
      rdQ     <= '0;
      shamtQ  <= '0;
      ctrlQ   <= '0;
      validQ  <= 1'b0;
      if (cntQ != '1) cntQ <= cntQ + CNT_W'(1);
    end else if (bus.Stall) begin
      rsDataQ <= rsHold;
      rtDataQ <= rtHold;
    end else begin
      pc4Q    <= bus.ID_PC4;
      immQ    <= bus.ID_ImmExt;
      rsDataQ <= rsLoad;
      rtDataQ <= rtLoad;
      rsQ     <= bus.ID_Rs;
      rtQ     <= bus.ID_Rt;
      rdQ     <= bus.ID_Rd;
      shamtQ  <= bus.ID_Shamt;
      ctrlQ   <= bus.ID_Ctrl;
      validQ  <= 1'b1;
    end
  end

  assign bus.EX_PC4    = pc4Q;
  assign bus.EX_ImmExt = immQ;
  assign bus.EX_RsData = rsDataQ;
  assign bus.EX_RtData = rtDataQ;
  assign bus.EX_Rs     = rsQ;
  assign bus.EX_Rt     = rtQ;
  assign bus.EX_Rd     = rdQ;
  assign bus.EX_Shamt  = shamtQ;
  assign bus.EX_Ctrl   = ctrlQ;
  assign bus.EX_Valid  = validQ;
  assign bus.BubbleCnt = cntQ;
endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: hand-written vector table, flush saturation run and
// random traffic, all scored against a reference model through an expected queue.
module tb_id_ex_reg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;
`ifdef ID_EX_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic rst, stall, flush;
    logic [31:0] pc4, imm, rsData, rtData;
    logic [4:0] rs, rt, rd, shamt;
    logic [15:0] ctrl;
    logic wbWe;
    logic [4:0] wbAddr;
    logic [31:0] wbData;
  } in_t;

  typedef struct packed {
    logic [31:0] pc4, imm, rsData, rtData;
    logic [4:0] rs, rt, rd, shamt;
    logic [15:0] ctrl;
    logic valid;
    logic [CNT_W-1:0] cnt;
  } out_t;

  typedef struct packed {
    in_t in;
    logic [31:0] eRs, eRt;
    logic [15:0] eCtrl;
    logic eValid;
    logic [3:0] eCnt;
  } vec_t;

  localparam int OUT_W = $bits(out_t);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_reg_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();
  id_ex_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [OUT_W-1:0] exp_q[$];
  out_t mdl;
  out_t got;
  int tests_run = 0;
  int tests_failed = 0;
  vec_t tbl[18];

  function automatic out_t model(input out_t cur, input in_t v);
    out_t n;
    logic wbLive;
    n = cur;
    wbLive = BYP && v.wbWe && (v.wbAddr != 5'd0);
    if (v.rst) begin
      n = '0;
    end else if (v.flush) begin
      n = '0;
      n.cnt = (cur.cnt == {CNT_W{1'b1}}) ? cur.cnt : cur.cnt + 1'b1;
    end else if (v.stall) begin
      if (wbLive && v.wbAddr == cur.rs) n.rsData = v.wbData;
      if (wbLive && v.wbAddr == cur.rt) n.rtData = v.wbData;
    end else begin
      n.pc4 = v.pc4; n.imm = v.imm; n.rs = v.rs; n.rt = v.rt;
      n.rd = v.rd; n.shamt = v.shamt; n.ctrl = v.ctrl; n.valid = 1'b1;
      n.rsData = (wbLive && v.wbAddr == v.rs) ? v.wbData : v.rsData;
      n.rtData = (wbLive && v.wbAddr == v.rt) ? v.wbData : v.rtData;
    end
    return n;
  endfunction

  function automatic vec_t row(input bit rst, input bit stall, input bit flush,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [31:0] rsD, input logic [31:0] rtD,
                               input logic [31:0] imm, input logic [15:0] ctrl,
                               input bit wbWe, input logic [4:0] wbA, input logic [31:0] wbD,
                               input logic [31:0] eRs, input logic [31:0] eRt,
                               input logic [15:0] eCtrl, input bit eV, input logic [3:0] eCnt);
    vec_t r;
    r = '0;
    r.in.rst = rst; r.in.stall = stall; r.in.flush = flush;
    r.in.rs = rs; r.in.rt = rt; r.in.rsData = rsD; r.in.rtData = rtD;
    r.in.imm = imm; r.in.ctrl = ctrl;
    r.in.wbWe = wbWe; r.in.wbAddr = wbA; r.in.wbData = wbD;
    r.eRs = eRs; r.eRt = eRt; r.eCtrl = eCtrl; r.eValid = eV; r.eCnt = eCnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive(input in_t v);
    reset            = v.rst;
    bus.Stall        = v.stall;
    bus.Flush        = v.flush;
    bus.ID_PC4       = v.pc4;
    bus.ID_ImmExt    = v.imm;
    bus.ID_RsData    = v.rsData;
    bus.ID_RtData    = v.rtData;
    bus.ID_Rs        = v.rs;
    bus.ID_Rt        = v.rt;
    bus.ID_Rd        = v.rd;
    bus.ID_Shamt     = v.shamt;
    bus.ID_Ctrl      = v.ctrl;
    bus.WB_RegWrite  = v.wbWe;
    bus.WB_WriteAddr = v.wbAddr;
    bus.WB_WriteData = v.wbData;
  endtask

  // Drive one cycle of stimulus, queue the model result, compare after the edge.
  task automatic step(input in_t v, input string name);
    drive(v);
    mdl = model(mdl, v);
    exp_q.push_back(mdl);
    @(posedge clk);
    #1;
    got = '{pc4: bus.EX_PC4, imm: bus.EX_ImmExt, rsData: bus.EX_RsData,
            rtData: bus.EX_RtData, rs: bus.EX_Rs, rt: bus.EX_Rt, rd: bus.EX_Rd,
            shamt: bus.EX_Shamt, ctrl: bus.EX_Ctrl, valid: bus.EX_Valid,
            cnt: bus.BubbleCnt};
    check(name, got, exp_q.pop_front());
  endtask

  initial begin
    in_t v;
    mdl = '0;

    tbl[0]  = row(1,0,0, 0,0, 32'h0, 32'h0, 32'hFFFF8000, 16'h0001, 0,0,0, 0, 0, 16'h0, 0, 0);
    tbl[1]  = row(1,0,0, 0,0, 32'h0, 32'h0, 32'hFFFF8000, 16'h0001, 0,0,0, 0, 0, 16'h0, 0, 0);
    tbl[2]  = row(0,0,0, 0,0, 32'h0, 32'h0, 32'hFFFF8000, 16'h0001, 0,0,0, 0, 0, 16'h0001, 1, 0);
    tbl[3]  = row(0,0,0, 1,2, 32'h12345678, 32'h0, 32'h4, 16'h0003, 0,0,0, 32'h12345678, 0, 16'h0003, 1, 0);
    tbl[4]  = row(0,1,0, 1,2, 32'hDEADBEEF, 32'h0, 32'h8, 16'h00FF, 0,0,0, 32'h12345678, 0, 16'h0003, 1, 0);
    tbl[5]  = row(0,1,0, 1,2, 32'hDEADBEEF, 32'h0, 32'h8, 16'h00FF, 0,0,0, 32'h12345678, 0, 16'h0003, 1, 0);
    tbl[6]  = row(0,1,0, 1,2, 32'hDEADBEEF, 32'h0, 32'h8, 16'h00FF, 0,0,0, 32'h12345678, 0, 16'h0003, 1, 0);
    tbl[7]  = row(0,0,0, 1,2, 32'hDEADBEEF, 32'h0, 32'h8, 16'h00FF, 0,0,0, 32'hDEADBEEF, 0, 16'h00FF, 1, 0);
    tbl[8]  = row(0,1,1, 1,2, 32'h1, 32'h2, 32'hC, 16'h3FFF, 0,0,0, 0, 0, 16'h0, 0, 1);
    tbl[9]  = row(0,0,0, 5,6, 32'h1, 32'h2, 32'h10, 16'h0001, 1,5,32'hAA,
                  BYP ? 32'hAA : 32'h1, 32'h2, 16'h0001, 1, 1);
    tbl[10] = row(0,0,0, 5,6, 32'h1, 32'h2, 32'h10, 16'h0001, 1,0,32'hAA, 32'h1, 32'h2, 16'h0001, 1, 1);
    tbl[11] = row(0,0,0, 3,9, 32'h11, 32'h33, 32'h14, 16'h0201, 0,0,0, 32'h11, 32'h33, 16'h0201, 1, 1);
    tbl[12] = row(0,1,0, 4,4, 32'h66, 32'h44, 32'h18, 16'h0004, 1,9,32'h77,
                  32'h11, BYP ? 32'h77 : 32'h33, 16'h0201, 1, 1);
    tbl[13] = row(0,1,0, 4,4, 32'h66, 32'h44, 32'h18, 16'h0004, 0,9,32'h88,
                  32'h11, BYP ? 32'h77 : 32'h33, 16'h0201, 1, 1);
    tbl[14] = row(0,0,0, 0,0, 32'h0, 32'h55, 32'h1C, 16'h2000, 1,0,32'h99, 32'h0, 32'h55, 16'h2000, 1, 1);
    tbl[15] = row(0,0,1, 7,8, 32'h5, 32'h6, 32'h20, 16'hFFFF, 0,0,0, 0, 0, 16'h0, 0, 2);
    tbl[16] = row(1,1,1, 7,8, 32'h5, 32'h6, 32'h20, 16'hFFFF, 0,0,0, 0, 0, 16'h0, 0, 0);
    tbl[17] = row(0,0,0, 7,8, 32'hCAFE, 32'h6, 32'h24, 16'h1234, 0,0,0, 32'hCAFE, 32'h6, 16'h1234, 1, 0);

    for (int i = 0; i < 18; i++) begin
      v = tbl[i].in;
      v.pc4   = 32'h0040_0000 + 32'(i * 4);
      v.rd    = 5'(i);
      v.shamt = 5'(31 - i);
      step(v, $sformatf("table_model%0d", i));
      check($sformatf("table_row%0d", i),
            OUT_W'({got.rsData, got.rtData, got.ctrl, got.valid, got.cnt}),
            OUT_W'({tbl[i].eRs, tbl[i].eRt, tbl[i].eCtrl, tbl[i].eValid, tbl[i].eCnt}));
    end

    // Twenty back-to-back flushes: the counter must stop at all-ones.
    v = '0;
    v.rst = 1'b1;
    step(v, "sat_reset");
    for (int k = 1; k <= 20; k++) begin
      v = '0;
      v.flush = 1'b1;
      v.ctrl  = 16'h3FFF;
      v.stall = (k % 3 == 0);
      step(v, $sformatf("sat_model%0d", k));
      check($sformatf("sat_cnt%0d", k), OUT_W'(got.cnt), OUT_W'((k > 15) ? 15 : k));
    end

    for (int n = 0; n < 300; n++) begin
      v.rst    = ($urandom_range(0, 49) == 0);
      v.flush  = ($urandom_range(0, 7) == 0);
      v.stall  = ($urandom_range(0, 3) == 0);
      v.pc4    = $urandom;
      v.imm    = $urandom;
      v.rsData = $urandom;
      v.rtData = $urandom;
      v.rs     = 5'($urandom_range(0, 3));
      v.rt     = 5'($urandom_range(0, 3));
      v.rd     = 5'($urandom_range(0, 31));
      v.shamt  = 5'($urandom_range(0, 31));
      v.ctrl   = 16'($urandom_range(0, 65535));
      v.wbWe   = 1'($urandom_range(0, 1));
      v.wbAddr = 5'($urandom_range(0, 3));
      v.wbData = $urandom;
      step(v, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
